seq_detector_param: RTL and testbench

//   Parametrised Moore-style serial pattern detector, successor to the fixed 4-bit "1101" detector.

---
 rtl/seq_detector_param.sv | 114 +++++++++++
 tb/tb_seq_detector_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: programmable pattern/length, overlap or
// non-overlap matching, input-valid qualifier and a saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_cfg,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               overlap_en,
    input  logic               clr_count,
    input  logic               i_valid,
    input  logic               i,
    output logic               o,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(4'b1101);
    localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(4);

    logic [MAX_LEN-1:0] history_reg, history_next;
    logic [LEN_W-1:0]   fill_reg, fill_next;
    logic [MAX_LEN-1:0] pattern_reg, pattern_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic               overlap_reg, overlap_next;
    logic               cfg_err_reg, cfg_err_next;
    logic               o_reg, o_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               hit;

    // Only the low len bits of history/pattern take part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_reg);
        end
    endgenerate

    assign hist_shift = {history_reg[MAX_LEN-2:0], i};
    assign fill_inc   = (fill_reg == MAX_LEN_L) ? fill_reg : fill_reg + LEN_W'(1);
    assign hit        = i_valid && !load_cfg && !cfg_err_reg
                        && (fill_inc >= len_reg)
                        && (((hist_shift ^ pattern_reg) & len_mask) == '0);

    always_comb begin
        history_next = history_reg;
        fill_next    = fill_reg;
        pattern_next = pattern_reg;
        len_next     = len_reg;
        overlap_next = overlap_reg;
        cfg_err_next = cfg_err_reg;
        o_next       = 1'b0;
        count_next   = count_reg;

        if (load_cfg) begin
            pattern_next = pattern_in;
            len_next     = len_in;
            overlap_next = overlap_en;
            cfg_err_next = (len_in == '0) || (len_in > MAX_LEN_L);
            history_next = '0;
            fill_next    = '0;
        end else if (i_valid) begin
            history_next = hist_shift;
            fill_next    = fill_inc;
            o_next       = hit;
            // Non-overlap: the next match must be built from fresh bits only.
            if (hit && !overlap_reg) begin
                fill_next = '0;
            end
        end

        if (clr_count) begin
            count_next = '0;
        end else if (hit && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_reg <= '0;
            fill_reg    <= '0;
            pattern_reg <= RST_PATTERN;
            len_reg     <= RST_LEN;
            overlap_reg <= 1'b1;
            cfg_err_reg <= 1'b0;
            o_reg       <= 1'b0;
            count_reg   <= '0;
        end else begin
            history_reg <= history_next;
            fill_reg    <= fill_next;
            pattern_reg <= pattern_next;
            len_reg     <= len_next;
            overlap_reg <= overlap_next;
            cfg_err_reg <= cfg_err_next;
            o_reg       <= o_next;
            count_reg   <= count_next;
        end
    end

    assign o           = o_reg;
    assign match_count = count_reg;
    assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised bench for seq_detector_param; a queue-based model of received bits
// predicts o, match_count (8-bit and 2-bit counter instances) and cfg_err.
module tb_seq_detector_param;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       load_cfg;
    logic [7:0] pattern_in;
    logic [3:0] len_in;
    logic       overlap_en;
    logic       clr_count;
    logic       i_valid;
    logic       i_bit;
    logic       o, o2;
    logic [7:0] match_count;
    logic [1:0] match_count2;
    logic       cfg_err, cfg_err2;

    always #5 tb_clk = ~tb_clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(tb_clk), .rst(rst), .load_cfg(load_cfg), .pattern_in(pattern_in),
        .len_in(len_in), .overlap_en(overlap_en), .clr_count(clr_count),
        .i_valid(i_valid), .i(i_bit), .o(o), .match_count(match_count), .cfg_err(cfg_err)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(tb_clk), .rst(rst), .load_cfg(load_cfg), .pattern_in(pattern_in),
        .len_in(len_in), .overlap_en(overlap_en), .clr_count(clr_count),
        .i_valid(i_valid), .i(i_bit), .o(o2), .match_count(match_count2), .cfg_err(cfg_err2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference model: bits received since the last reset/load/non-overlap match.
    bit       q[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_err;
    bit       exp_o;
    int       exp_cnt;
    int       exp_cnt2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pat    = 8'b0000_1101;
        m_len    = 4;
        m_ovl    = 1'b1;
        m_err    = 1'b0;
        exp_o    = 1'b0;
        exp_cnt  = 0;
        exp_cnt2 = 0;
    endtask

    task automatic model_edge();
        bit m;
        m = 1'b0;
        if (load_cfg) begin
            m_pat = pattern_in;
            m_len = int'(len_in);
            m_ovl = overlap_en;
            m_err = (len_in == 4'd0) || (len_in > 4'd8);
            q.delete();
        end else if (i_valid) begin
            q.push_back(i_bit);
            if (q.size() > 8) void'(q.pop_front());
            if (!m_err && q.size() >= m_len) begin
                m = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (q[q.size() - 1 - k] != m_pat[k]) m = 1'b0;
            end
            if (m && !m_ovl) q.delete();
        end
        exp_o = m;
        if (clr_count) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else if (m) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_o"}, o, exp_o);
        check_val({tag, "_o2"}, o2, exp_o);
        check_val({tag, "_cnt"}, match_count, exp_cnt);
        check_val({tag, "_cnt2"}, match_count2, exp_cnt2);
        check_val({tag, "_err"}, cfg_err, m_err);
        check_val({tag, "_err2"}, cfg_err2, m_err);
    endtask

    task automatic step(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                        input bit ovl, input bit clr, input bit v, input bit b);
        @(negedge tb_clk);
        load_cfg   = ld;
        pattern_in = pat;
        len_in     = len;
        overlap_en = ovl;
        clr_count  = clr;
        i_valid    = v;
        i_bit      = b;
        @(posedge tb_clk);
        model_edge();
        #1;
        n_txn++;
        $display("txn %0d ld=%0b clr=%0b v=%0b i=%0b -> o=%0b cnt=%0d cnt2=%0d err=%0b",
                 n_txn, ld, clr, v, b, o, match_count, match_count2, cfg_err);
        check_all("step");
    endtask

    task automatic send(input bit b);
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        step(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges, check outputs before the next edge, release at negedge.
    task automatic rst_pulse();
        idle();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge tb_clk);
        rst = 1'b0;
        #1;
        check_val("rst_rel_o", o, 1'b0);
    endtask

    initial begin
        rst = 1'b1; load_cfg = 0; pattern_in = 0; len_in = 0; overlap_en = 0;
        clr_count = 0; i_valid = 0; i_bit = 0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge tb_clk);
        rst = 1'b0;

        // Default config: 1101
        send(1); send(1); send(0); send(1);
        check_val("t2_o", o, 1'b1);
        check_val("t2_cnt", match_count, 8'd1);
        send(0);
        check_val("t2_o_low", o, 1'b0);

        // Overlap on: two matches in 1101101
        clear();
        foreach (q[k]) ;
        send(1); send(1); send(0); send(1); send(1); send(0); send(1);
        check_val("t3_ovl_cnt", match_count, 8'd2);
        // Overlap off: one match
        load(8'b0000_1101, 4'd4, 1'b0);
        clear();
        send(1); send(1); send(0); send(1); send(1); send(0); send(1);
        check_val("t3_novl_cnt", match_count, 8'd1);

        // Gaps of 3 invalid cycles between bits
        load(8'b0000_1101, 4'd4, 1'b1);
        clear();
        send(1); repeat (3) idle();
        send(1); repeat (3) idle();
        send(0); repeat (3) idle();
        send(1);
        check_val("t4_o", o, 1'b1);
        idle();
        check_val("t4_gap_o", o, 1'b0);
        check_val("t4_cnt", match_count, 8'd1);

        // Mid-stream reload discards prior bits; then an 8-bit pattern
        load(8'b1010_0111, 4'd8, 1'b1);
        clear();
        send(1); send(0); send(1);
        load(8'b1010_0111, 4'd8, 1'b1);
        for (int k = 7; k >= 0; k--) begin
            logic [7:0] p;
            p = 8'b1010_0111;
            send(p[k]);
        end
        check_val("t5_cnt", match_count, 8'd1);
        check_val("t5_o", o, 1'b1);
        load(8'h00, 4'd0, 1'b1);
        check_val("t5_err", cfg_err, 1'b1);
        repeat (20) send(1'($urandom_range(0, 1)));
        check_val("t5_err_cnt", match_count, 8'd1);
        load(8'h00, 4'd9, 1'b1);
        check_val("t5_err9", cfg_err, 1'b1);

        // 2-bit counter saturation, then clr coincident with a match
        load(8'b0000_0001, 4'd1, 1'b1);
        clear();
        send(1); check_val("t6_c1", match_count2, 2'd1);
        send(1); check_val("t6_c2", match_count2, 2'd2);
        send(1); check_val("t6_c3", match_count2, 2'd3);
        send(1); check_val("t6_c4", match_count2, 2'd3);
        send(1); check_val("t6_c5", match_count2, 2'd3);
        step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("t6_clr_cnt", match_count, 8'd0);
        check_val("t6_clr_o", o, 1'b1);

        // 8-bit counter saturation
        repeat (260) send(1);
        check_val("t6_sat8", match_count, 8'd255);

        // Reset during FILLING loses the partial bits
        load(8'b0000_1101, 4'd4, 1'b1);
        send(1); send(1); send(0);
        rst_pulse();
        send(1);
        check_val("t6_rst_nomatch", o, 1'b0);
        send(1); send(0); send(1);
        check_val("t6_rst_match", o, 1'b1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 5)
                load(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            else if (r < 9)
                step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (r < 10)
                rst_pulse();
            else
                step(1'b0, 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
